// File: rtl/rx_shift.sv
// UART receive shifter: 2-flop synchronized rx, mid-bit oversampled sampling,
// 8N2 framing with frame-error, overrun and data-ready handshake.
module rx_shift #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       uart_clk,
    input  logic       reset_n,
    input  logic       sample_tick,
    input  logic       rx,
    input  logic       data_ack,
    output logic [7:0] data_out,
    output logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] MID_LAST  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic             stop_err;
    logic             rx_m;
    logic             rx_s;

    always_ff @(posedge uart_clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            stop_err   <= 1'b0;
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            data_out   <= '0;
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // A completing byte later in this block overrides the ack clear.
            if (data_ack) begin
                data_ready <= 1'b0;
            end
            if (sample_tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt == MID_LAST) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_s, shreg[7:1]};
                            if (bit_cnt == 3'd7) begin
                                state   <= STOP;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (tick_cnt == FULL_LAST) begin
                            tick_cnt <= '0;
                            if (bit_cnt == 3'd0) begin
                                bit_cnt  <= 3'd1;
                                stop_err <= ~rx_s;
                            end else begin
                                bit_cnt <= '0;
                                if (stop_err || !rx_s) begin
                                    frame_err <= 1'b1;
                                    if (!rx_s) begin
                                        state <= WAIT_IDLE;
                                    end else begin
                                        state <= IDLE;
                                        busy  <= 1'b0;
                                    end
                                end else begin
                                    data_out   <= shreg;
                                    data_ready <= 1'b1;
                                    overrun    <= data_ready & ~data_ack;
                                    state      <= IDLE;
                                    busy       <= 1'b0;
                                end
                            end
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                    WAIT_IDLE: begin
                        // Line break holds the receiver until rx returns high.
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
